// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Single-outstanding AXI4-Lite initiator. A local requester hands over one
//   read or write at a time on a valid/ready request port. The block issues
//   it on the M_AXI side and returns the result on a held response channel.
//
// Ports
//   aclk, arst        clock, asynchronous active-high reset
//   req_*             request channel (valid/ready, write, addr, wdata, wstrb, prot)
//   rsp_*             response channel (valid/ready, rdata, resp)
//   timeout           sticky flag: current/last transaction ran past TIMEOUT_CYCLES
//   M_AXI_*           AXI4-Lite master interface (AW, W, B, AR, R)
module axi_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    arst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [2:0]              req_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout,

    output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
    output logic [2:0]              M_AXI_awprot,
    output logic                    M_AXI_awvalid,
    input  logic                    M_AXI_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
    output logic                    M_AXI_wvalid,
    input  logic                    M_AXI_wready,
    input  logic [1:0]              M_AXI_bresp,
    input  logic                    M_AXI_bvalid,
    output logic                    M_AXI_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
    output logic [2:0]              M_AXI_arprot,
    output logic                    M_AXI_arvalid,
    input  logic                    M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
    input  logic [1:0]              M_AXI_rresp,
    input  logic                    M_AXI_rvalid,
    output logic                    M_AXI_rready
);

    localparam int SW = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    // Counter only needs to reach TIMEOUT_CYCLES, where it saturates.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         wstrb;
        logic [2:0]            prot;
    } req_t;

    logic [2:0]    state;
    req_t          req_q;
    logic          aw_done, w_done;
    logic          aw_fin, w_fin;
    logic          busy;
    logic [CW-1:0] cnt;

    // A channel is finished if it handshook earlier or is handshaking now.
    assign aw_fin = aw_done | (M_AXI_awvalid & M_AXI_awready);
    assign w_fin  = w_done  | (M_AXI_wvalid  & M_AXI_wready);
    assign busy   = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                    (state == S_RD_REQ) || (state == S_RD_DATA);

    // Every valid is a pure function of registered state, never of a ready.
    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RESP);
    assign M_AXI_awvalid = (state == S_WR_REQ) & ~aw_done;
    assign M_AXI_wvalid  = (state == S_WR_REQ) & ~w_done;
    assign M_AXI_bready  = (state == S_WR_RESP);
    assign M_AXI_arvalid = (state == S_RD_REQ);
    assign M_AXI_rready  = (state == S_RD_DATA);

    assign M_AXI_awaddr  = req_q.addr;
    assign M_AXI_awprot  = req_q.prot;
    assign M_AXI_wdata   = req_q.wdata;
    assign M_AXI_wstrb   = req_q.wstrb;
    assign M_AXI_araddr  = req_q.addr;
    assign M_AXI_arprot  = req_q.prot;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state     <= S_IDLE;
            req_q     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            cnt       <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_q   <= '{write: req_write, addr: req_addr, wdata: req_wdata,
                                     wstrb: req_wstrb, prot: req_prot};
                        cnt     <= '0;
                        timeout <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= req_write ? S_WR_REQ : S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) state <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (M_AXI_bvalid) begin
                        rsp_resp  <= M_AXI_bresp;
                        rsp_rdata <= '0;
                        state     <= S_RESP;
                    end
                end
                S_RD_REQ: begin
                    if (M_AXI_arready) state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (M_AXI_rvalid) begin
                        rsp_rdata <= M_AXI_rdata;
                        rsp_resp  <= M_AXI_rresp;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Timeout only flags; the transaction keeps waiting for its handshake.
            if (busy && (TIMEOUT_CYCLES != 0) && (cnt != TO_MAX)) begin
                cnt <= cnt + 1'b1;
                if (cnt == TO_LAST) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master. A transaction-level model follows each request
// from accept to response and is compared with the DUT outputs every cycle.
// Directed sequences add literal cycle-exact expectations.
module tb_axi_lite_master;

    localparam int TO = 8;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        req_valid = 0, req_ready, req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic [2:0]  req_prot = 0;
    logic        rsp_valid, rsp_ready = 0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic [31:0] awaddr, wdata, araddr, rdata = 0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 0, wvalid, wready = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic        bvalid = 0, bready, arvalid, arready = 0, rvalid = 0, rready;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .aclk(aclk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .timeout(timeout),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid),
        .M_AXI_awready(awready), .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb),
        .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_bresp(bresp),
        .M_AXI_bvalid(bvalid), .M_AXI_bready(bready), .M_AXI_araddr(araddr),
        .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid),
        .M_AXI_rready(rready)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_busy = 0, m_have = 0, m_write = 0, m_to = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_wstrb = 0;
    logic [2:0]  m_prot = 0;
    logic [1:0]  m_resp = 0;
    int          m_aw_n = 0, m_w_n = 0, m_ar_n = 0, m_cyc = 0;
    logic        aw_wait = 0, w_wait = 0, ar_wait = 0, rsp_wait = 0;

    always @(negedge aclk) begin
        if (arst) begin
            m_busy = 0; m_have = 0; m_to = 0;
            m_aw_n = 0; m_w_n = 0; m_ar_n = 0; m_cyc = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; rsp_wait = 0;
        end else begin
            chk("m_req_ready", req_ready, !m_busy);
            chk("m_rsp_valid", rsp_valid, m_have);
            chk("m_timeout", timeout, m_to);
            chk("m_bready", bready, m_busy && m_write && m_aw_n == 1 && m_w_n == 1 && !m_have);
            chk("m_rready", rready, m_busy && !m_write && m_ar_n == 1 && !m_have);
            if (aw_wait)  chk("m_aw_hold", awvalid, 1);
            if (w_wait)   chk("m_w_hold", wvalid, 1);
            if (ar_wait)  chk("m_ar_hold", arvalid, 1);
            if (rsp_wait) chk("m_rsp_hold", rsp_valid, 1);
            if (awvalid) begin
                chk("m_aw_legal", m_busy && m_write && m_aw_n == 0, 1);
                chk("m_awaddr", awaddr, m_addr);
                chk("m_awprot", awprot, m_prot);
            end
            if (wvalid) begin
                chk("m_w_legal", m_busy && m_write && m_w_n == 0, 1);
                chk("m_wdata", wdata, m_wdata);
                chk("m_wstrb", wstrb, m_wstrb);
            end
            if (arvalid) begin
                chk("m_ar_legal", m_busy && !m_write && m_ar_n == 0, 1);
                chk("m_araddr", araddr, m_addr);
                chk("m_arprot", arprot, m_prot);
            end
            if (rsp_valid) begin
                chk("m_rsp_rdata", rsp_rdata, m_rdata);
                chk("m_rsp_resp", rsp_resp, m_resp);
            end

            aw_wait  = awvalid & !awready;
            w_wait   = wvalid & !wready;
            ar_wait  = arvalid & !arready;
            rsp_wait = rsp_valid & !rsp_ready;

            // Issued cycles are counted from the first cycle after accept until the response is captured.
            if (m_busy && !m_have) begin
                m_cyc++;
                if (m_cyc == TO) m_to = 1;
            end
            if (awvalid && awready) m_aw_n++;
            if (wvalid && wready)   m_w_n++;
            if (arvalid && arready) m_ar_n++;
            if (bvalid && bready) begin
                m_have = 1; m_rdata = 0; m_resp = bresp;
            end
            if (rvalid && rready) begin
                m_have = 1; m_rdata = rdata; m_resp = rresp;
            end
            if (rsp_valid && rsp_ready) begin
                chk("m_aw_count", m_aw_n, m_write ? 1 : 0);
                chk("m_w_count",  m_w_n,  m_write ? 1 : 0);
                chk("m_ar_count", m_ar_n, m_write ? 0 : 1);
                m_busy = 0; m_have = 0; n_rsp++;
            end
            if (req_valid && req_ready) begin
                m_busy = 1; m_have = 0; m_to = 0; m_cyc = 0;
                m_write = req_write; m_addr = req_addr; m_wdata = req_wdata;
                m_wstrb = req_wstrb; m_prot = req_prot;
                m_aw_n = 0; m_w_n = 0; m_ar_n = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        req_wstrb = s; req_prot = p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rsp_before;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_awvalid", awvalid, 0); chk("rst_wvalid", wvalid, 0);
        chk("rst_arvalid", arvalid, 0); chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);   chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_timeout", timeout, 0); chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0); chk("rst_awaddr", awaddr, 0);
        arst = 0;
        tick();
        chk("rel_req_ready", req_ready, 1);

        // 1: write, everything immediate
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        do_req(1, 32'h0000_0104, 32'hA5A5_1234, 4'hF, 3'd0);
        tick(); req_valid = 0;
        chk("t1_awvalid_n1", awvalid, 1); chk("t1_wvalid_n1", wvalid, 1);
        chk("t1_awaddr", awaddr, 32'h0000_0104); chk("t1_wdata", wdata, 32'hA5A5_1234);
        chk("t1_req_ready_n1", req_ready, 0);
        tick();
        chk("t1_awvalid_n2", awvalid, 0); chk("t1_bready_n2", bready, 1);
        chk("t1_req_ready_n2", req_ready, 0);
        tick();
        chk("t1_rsp_valid_n3", rsp_valid, 1); chk("t1_rsp_resp", rsp_resp, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0); chk("t1_req_ready_n3", req_ready, 0);
        rsp_ready = 1;
        tick();
        chk("t1_rsp_valid_n4", rsp_valid, 0); chk("t1_req_ready_n4", req_ready, 1);
        rsp_ready = 0; bvalid = 0; awready = 0; wready = 0;

        // 2: write, W accepted late
        awready = 1;
        do_req(1, 32'h0000_0108, 32'h0BAD_F00D, 4'h3, 3'd2);
        tick(); req_valid = 0;
        chk("t2_awvalid_n1", awvalid, 1); chk("t2_wvalid_n1", wvalid, 1);
        tick();
        chk("t2_awvalid_n2", awvalid, 0); chk("t2_wvalid_n2", wvalid, 1);
        awready = 0;
        tick();
        chk("t2_wvalid_n3", wvalid, 1); chk("t2_wdata_n3", wdata, 32'h0BAD_F00D);
        tick();
        chk("t2_wvalid_n4", wvalid, 1); chk("t2_wstrb_n4", wstrb, 4'h3);
        wready = 1;
        tick();
        chk("t2_wvalid_n5", wvalid, 0); chk("t2_bready_n5", bready, 1);
        wready = 0; bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        chk("t2_rsp_valid", rsp_valid, 1); chk("t2_rsp_resp", rsp_resp, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        chk("t2_rsp_count", n_rsp, 2);

        // 3: read, AR and R delayed
        do_req(0, 32'h0000_0200, 32'h0, 4'h0, 3'd1);
        tick(); req_valid = 0;
        chk("t3_arvalid_n1", arvalid, 1); chk("t3_araddr_n1", araddr, 32'h0000_0200);
        tick();
        chk("t3_arvalid_n2", arvalid, 1);
        tick();
        chk("t3_arvalid_n3", arvalid, 1); chk("t3_araddr_n3", araddr, 32'h0000_0200);
        arready = 1;
        tick();
        chk("t3_arvalid_n4", arvalid, 0); chk("t3_rready_n4", rready, 1);
        arready = 0;
        tick(); tick();
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 0;
        chk("t3_rsp_valid", rsp_valid, 1); chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t3_timeout", timeout, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0;

        // 4: read with DECERR, requester stalls the response
        arready = 1;
        do_req(0, 32'h0000_0300, 32'h0, 4'h0, 3'd0);
        tick(); req_valid = 0;
        rvalid = 1; rdata = 32'h1357_9BDF; rresp = 2'b11;
        tick();
        chk("t4_rready", rready, 1);
        tick();
        rvalid = 0; arready = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid_hold", rsp_valid, 1); chk("t4_rsp_resp_hold", rsp_resp, 3);
            chk("t4_req_ready_low", req_ready, 0);
            tick();
        end
        rsp_ready = 1;
        tick();
        chk("t4_req_ready_after", req_ready, 1); chk("t4_rsp_valid_after", rsp_valid, 0);
        rsp_ready = 0;

        // 5: timeout while AR is withheld for 20 cycles
        do_req(0, 32'h0000_0400, 32'h0, 4'h0, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            tick(); req_valid = 0;
            chk("t5_arvalid", arvalid, 1);
            chk("t5_timeout", timeout, (k >= 9) ? 1'b1 : 1'b0);
        end
        tick();
        arready = 1;
        chk("t5_arvalid_n21", arvalid, 1); chk("t5_timeout_n21", timeout, 1);
        tick();
        arready = 0; rvalid = 1; rdata = 32'hCAFE_0001; rresp = 2'b00;
        tick();
        rvalid = 0;
        chk("t5_rsp_valid", rsp_valid, 1); chk("t5_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("t5_timeout_rsp", timeout, 1);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        chk("t5_timeout_idle", timeout, 1);
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
        do_req(1, 32'h0000_0500, 32'h0000_00FF, 4'h1, 3'd0);
        tick(); req_valid = 0;
        chk("t5_timeout_clr", timeout, 0);
        tick(); tick();
        chk("t5b_rsp_valid", rsp_valid, 1); chk("t5b_rsp_resp", rsp_resp, 2);
        rsp_ready = 1;
        tick();
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0;

        // 6: reset in the middle of a write
        rsp_before = n_rsp;
        do_req(1, 32'h0000_0600, 32'h1111_2222, 4'hF, 3'd0);
        tick(); req_valid = 0;
        chk("t6_awvalid_pre", awvalid, 1);
        arst = 1;
        #1;
        chk("t6_awvalid_rst", awvalid, 0); chk("t6_wvalid_rst", wvalid, 0);
        chk("t6_arvalid_rst", arvalid, 0); chk("t6_bready_rst", bready, 0);
        chk("t6_rsp_valid_rst", rsp_valid, 0);
        @(negedge aclk); #2;
        arst = 0;
        tick();
        chk("t6_req_ready", req_ready, 1);
        tick(); tick();
        chk("t6_no_rsp", rsp_valid, 0); chk("t6_rsp_count", n_rsp, rsp_before);
        arready = 1; rvalid = 1; rdata = 32'h0000_7777; rresp = 2'b00;
        do_req(0, 32'h0000_0700, 32'h0, 4'h0, 3'd0);
        tick(); req_valid = 0;
        tick(); tick();
        chk("t6_rd_rsp_valid", rsp_valid, 1); chk("t6_rd_rdata", rsp_rdata, 32'h0000_7777);
        rsp_ready = 1;
        tick();
        rsp_ready = 0; arready = 0; rvalid = 0;
        chk("t6_rsp_count_after", n_rsp, rsp_before + 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
